// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state instruction sequencer wrapped around a 4-bit ALU.
// Accepts one 9-bit instruction per handshake, reads two operands from a
// 4 x 4-bit register file, latches the ALU outputs, then retires with a
// single-cycle done pulse and writes the result back.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | instr_ready=1, waiting for instr_valid
//   EXEC  | operands read from regfile, ALU outputs latched into hold regs
//   WB    | done=1, result/regfile/flags committed at the closing edge

module alu_sequencer_alu (
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [4:0] sum;
  logic [4:0] diff;

  // Combinational ALU; carry on SUB is the inverted borrow (1 = no borrow).
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    y         = 4'h0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (op)
      OP_ADD: begin
        y         = sum[3:0];
        carry_out = sum[4];
        overflow  = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      OP_SUB: begin
        y         = diff[3:0];
        carry_out = ~diff[4];
        overflow  = (a[3] != b[3]) && (diff[3] != a[3]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {3'b000, ($signed(a) < $signed(b))};
      default: y = 4'h0;
    endcase
    zero = (y == 4'h0);
  end

endmodule

module alu_sequencer #(
  parameter logic [3:0] REG_INIT = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [8:0] instr,
  output logic       done,
  output logic [3:0] result,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data
);

  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] instr_q;
  logic [3:0] regs [4];

  logic [3:0] hold_y;
  logic       hold_c, hold_v, hold_z;

  logic [2:0] op_q;
  logic [1:0] rd_q, rs1_q, rs2_q;
  logic [3:0] imm_q;

  logic [3:0] alu_y;
  logic       alu_c, alu_v, alu_z;
  logic       handshake;

  assign op_q  = instr_q[8:6];
  assign rd_q  = instr_q[5:4];
  assign rs1_q = instr_q[3:2];
  assign rs2_q = instr_q[1:0];
  assign imm_q = instr_q[3:0];

  assign handshake = instr_valid && instr_ready;
  assign dbg_data  = regs[dbg_addr];

  alu_sequencer_alu u_alu (
    .op        (op_q),
    .a         (regs[rs1_q]),
    .b         (regs[rs2_q]),
    .y         (alu_y),
    .carry_out (alu_c),
    .overflow  (alu_v),
    .zero      (alu_z)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/retire strobes.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction register: loaded only on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         instr_q <= 9'h000;
    else if (handshake) instr_q <= instr;
  end

  // Hold registers capture ALU (or LI immediate) outputs during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_y <= 4'h0;
      hold_c <= 1'b0;
      hold_v <= 1'b0;
      hold_z <= 1'b0;
    end else if (state == EXEC) begin
      if (op_q == OP_LI) begin
        hold_y <= imm_q;
        hold_c <= 1'b0;
        hold_v <= 1'b0;
        hold_z <= (imm_q == 4'h0);
      end else begin
        hold_y <= alu_y;
        hold_c <= alu_c;
        hold_v <= alu_v;
        hold_z <= alu_z;
      end
    end
  end

  // Writeback: result always, regfile and flags only for non-NOP ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= 4'h0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_z <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= REG_INIT;
    end else if (state == WB) begin
      if (op_q == OP_NOP) begin
        result <= 4'h0;
      end else begin
        result     <= hold_y;
        regs[rd_q] <= hold_y;
        flag_c     <= hold_c;
        flag_v     <= hold_v;
        flag_z     <= hold_z;
      end
    end
  end

endmodule
